cpu_perf_monitor: RTL and testbench

CPU_PERF_MONITOR -- requirements
Module: cpu_perf_monitor

---
 rtl/cpu_perf_monitor.sv | 103 ++++++++++
 tb/tb_cpu_perf_monitor.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_perf_monitor.sv
// Performance monitor: counts cycles and retired instructions from a start request
// until the observed core reaches TARGET_PC or stalls for STALL_LIMIT cycles.
module cpu_perf_monitor #(
    parameter logic [31:0] TARGET_PC   = 32'd400,
    parameter int          STALL_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        clear,
    input  logic [31:0] pc,
    input  logic        retire,
    output logic        busy,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count,
    output logic        timeout,
    output logic [1:0]  state_dbg
);
    // Result handshake: results are offered while result_valid is high and are taken
    // on the first edge where result_ready is also high; result_valid holds until then.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int SW = $clog2(STALL_LIMIT + 1);

    state_t        state;
    logic [SW-1:0] stall_cnt;
    logic [SW-1:0] stall_inc;
    logic [31:0]   cycle_inc;
    logic [31:0]   instr_inc;
    logic          hit_target;
    logic          hit_stall;

    always_comb begin
        stall_inc  = stall_cnt + 1'b1;
        cycle_inc  = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
        instr_inc  = (instr_count == 32'hFFFF_FFFF) ? instr_count : instr_count + 32'd1;
        hit_target = (pc >= TARGET_PC);
        // The stall counter is about to reach the limit in this cycle.
        hit_stall  = !retire && (stall_inc == SW'(STALL_LIMIT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cycle_count <= '0;
            instr_count <= '0;
            timeout     <= 1'b0;
            stall_cnt   <= '0;
        end else if (clear) begin
            state       <= S_IDLE;
            cycle_count <= '0;
            instr_count <= '0;
            timeout     <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_RUN;
                        cycle_count <= '0;
                        instr_count <= '0;
                        timeout     <= 1'b0;
                        stall_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    cycle_count <= cycle_inc;
                    if (retire) begin
                        instr_count <= instr_inc;
                        stall_cnt   <= '0;
                    end else begin
                        stall_cnt   <= stall_inc;
                    end
                    // Reaching the target wins over a simultaneous stall timeout.
                    if (hit_target) begin
                        state   <= S_DONE;
                        timeout <= 1'b0;
                    end else if (hit_stall) begin
                        state   <= S_DONE;
                        timeout <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy         = (state == S_RUN);
    assign result_valid = (state == S_DONE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_cpu_perf_monitor.sv
// Self-checking bench for cpu_perf_monitor: directed scenarios plus randomized runs
// scored against a window-based reference model of the run-termination rules.
module tb_cpu_perf_monitor;
    localparam logic [31:0] TARGET = 32'd400;
    localparam int          LIMIT  = 16;
    localparam int          MAXC   = 1200;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        retire = 1'b0;
    logic        result_ready = 1'b0;
    logic        busy;
    logic        result_valid;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
    logic        timeout;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad = 0;

    // Scoreboard entries are {timeout, instr_count, cycle_count}.
    logic [64:0] exp_q[$];
    logic [31:0] pc_arr[MAXC];
    logic        ret_arr[MAXC];

    cpu_perf_monitor #(.TARGET_PC(TARGET), .STALL_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear), .pc(pc),
        .retire(retire), .busy(busy), .result_valid(result_valid),
        .result_ready(result_ready), .cycle_count(cycle_count),
        .instr_count(instr_count), .timeout(timeout), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit stall_window(input int i);
        if (i < LIMIT - 1) return 1'b0;
        for (int j = i - LIMIT + 1; j <= i; j++)
            if (ret_arr[j]) return 1'b0;
        return 1'b1;
    endfunction

    // Returns the index of the terminating RUN cycle; optionally queues its results.
    function automatic int model_end(input bit push);
        int ones = 0;
        for (int i = 0; i < MAXC; i++) begin
            if (ret_arr[i]) ones++;
            if (pc_arr[i] >= TARGET) begin
                if (push) exp_q.push_back({1'b0, 32'(ones), 32'(i + 1)});
                return i;
            end
            if (stall_window(i)) begin
                if (push) exp_q.push_back({1'b1, 32'(ones), 32'(i + 1)});
                return i;
            end
        end
        return MAXC - 1;
    endfunction

    // ---------------- stimulus generators ----------------
    task automatic fill_linear(input int step_every);
        logic [31:0] p;
        p = 32'd0;
        for (int i = 0; i < MAXC; i++) begin
            pc_arr[i]  = p;
            ret_arr[i] = (p < TARGET) && ((i % step_every) == 0);
            if (ret_arr[i]) p = p + 32'd4;
        end
    endtask

    task automatic gen_random();
        logic [31:0] p;
        int pct;
        p   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FF00 : 32'($urandom_range(0, 300));
        pct = $urandom_range(5, 95);
        for (int i = 0; i < MAXC; i++) begin
            if (i >= 1000) begin
                pc_arr[i]  = TARGET;
                ret_arr[i] = 1'b0;
            end else begin
                pc_arr[i]  = p;
                ret_arr[i] = ($urandom_range(0, 99) < pct);
                if (ret_arr[i])
                    p = p + 32'd4 + (($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 40)) * 32'd4 : 32'd0);
            end
        end
    endtask

    // ---------------- driver + scoreboard check ----------------
    task automatic run_and_check(input string name, input bit do_start, input int ready_delay,
                                 input bit handshake);
        int last;
        logic [64:0] exp;
        last = model_end(1'b0);
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int i = 0; i <= last; i++) begin
            pc     = pc_arr[i];
            retire = ret_arr[i];
            start  = ($urandom_range(0, 7) == 0);
            tick();
            if (i < last) begin
                total++;
                if (busy !== 1'b1 || result_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_run_cycle%0d: busy=%b rv=%b required busy=1 rv=0", name, i, busy, result_valid);
                end
            end
        end
        start  = 1'b0;
        retire = 1'b0;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_scoreboard: expected queue empty, required one entry", name);
            return;
        end
        exp = exp_q.pop_front();
        total++;
        if (result_valid !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_done: busy=%b rv=%b required busy=0 rv=1", name, busy, result_valid);
        end
        total++;
        if ({timeout, instr_count, cycle_count} !== exp) begin
            bad++;
            $display("FAIL %s_results: timeout=%b instr=%0d cycles=%0d required timeout=%b instr=%0d cycles=%0d",
                     name, timeout, instr_count, cycle_count, exp[64], exp[63:32], exp[31:0]);
        end
        for (int k = 0; k < ready_delay; k++) begin
            start = $urandom_range(0, 1);
            tick();
            total++;
            if (result_valid !== 1'b1 || {timeout, instr_count, cycle_count} !== exp) begin
                bad++;
                $display("FAIL %s_hold%0d: rv=%b instr=%0d cycles=%0d required rv=1 instr=%0d cycles=%0d",
                         name, k, result_valid, instr_count, cycle_count, exp[63:32], exp[31:0]);
            end
        end
        start = 1'b0;
        if (!handshake) return;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        total++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || {timeout, instr_count, cycle_count} !== exp) begin
            bad++;
            $display("FAIL %s_idle: rv=%b busy=%b instr=%0d cycles=%0d required rv=0 busy=0 instr=%0d cycles=%0d",
                     name, result_valid, busy, instr_count, cycle_count, exp[63:32], exp[31:0]);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        total++;
        if ({busy, result_valid, timeout, cycle_count, instr_count, state_dbg} !== 69'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b rv=%b to=%b cyc=%0d ins=%0d st=%0d required all 0",
                     busy, result_valid, timeout, cycle_count, instr_count, state_dbg);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_linear();
        fill_linear(1);
        exp_q.push_back({1'b0, 32'd100, 32'd101});
        run_and_check("linear", 1'b1, 0, 1'b1);
    endtask

    task automatic test_alternate();
        fill_linear(2);
        exp_q.push_back({1'b0, 32'd100, 32'd200});
        run_and_check("alternate", 1'b1, 0, 1'b1);
    endtask

    task automatic test_stall();
        for (int i = 0; i < MAXC; i++) begin
            pc_arr[i]  = 32'd8;
            ret_arr[i] = 1'b0;
        end
        exp_q.push_back({1'b1, 32'd0, 32'd16});
        run_and_check("stall", 1'b1, 5, 1'b1);
    endtask

    task automatic test_stall_after_retires();
        for (int i = 0; i < MAXC; i++) begin
            pc_arr[i]  = (i < 5) ? 32'(i * 4) : 32'd20;
            ret_arr[i] = (i < 5);
        end
        exp_q.push_back({1'b1, 32'd5, 32'd21});
        run_and_check("stall_late", 1'b1, 2, 1'b1);
    endtask

    task automatic test_priority();
        for (int i = 0; i < MAXC; i++) begin
            pc_arr[i]  = (i < 15) ? 32'd8 : TARGET;
            ret_arr[i] = 1'b0;
        end
        exp_q.push_back({1'b0, 32'd0, 32'd16});
        run_and_check("priority", 1'b1, 1, 1'b1);
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 37; i++) begin
            pc     = 32'(i * 4);
            retire = 1'b1;
            tick();
        end
        retire = 1'b0;
        total++;
        if (cycle_count !== 32'd37 || instr_count !== 32'd37) begin
            bad++;
            $display("FAIL async_pre: cyc=%0d ins=%0d required 37 37", cycle_count, instr_count);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({busy, result_valid, timeout, cycle_count, instr_count} !== 67'd0) begin
            bad++;
            $display("FAIL async_reset: busy=%b rv=%b to=%b cyc=%0d ins=%0d required all 0",
                     busy, result_valid, timeout, cycle_count, instr_count);
        end
        #2;
        reset = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || cycle_count !== 32'd0 || instr_count !== 32'd0) begin
            bad++;
            $display("FAIL async_restart: busy=%b cyc=%0d ins=%0d required 1 0 0", busy, cycle_count, instr_count);
        end
        fill_linear(1);
        exp_q.push_back({1'b0, 32'd100, 32'd101});
        run_and_check("async_rerun", 1'b0, 0, 1'b1);
    endtask

    task automatic test_clear_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pc     = 32'(i * 4);
            retire = 1'b1;
            tick();
        end
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if ({busy, result_valid, timeout, cycle_count, instr_count} !== 67'd0) begin
            bad++;
            $display("FAIL clear_run: busy=%b rv=%b to=%b cyc=%0d ins=%0d required all 0",
                     busy, result_valid, timeout, cycle_count, instr_count);
        end
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || cycle_count !== 32'd0) begin
            bad++;
            $display("FAIL clear_restart: busy=%b cyc=%0d required busy=1 cyc=0", busy, cycle_count);
        end
        fill_linear(1);
        exp_q.push_back({1'b0, 32'd100, 32'd101});
        run_and_check("clear_rerun", 1'b0, 0, 1'b1);
    endtask

    task automatic test_clear_done();
        for (int i = 0; i < MAXC; i++) begin
            pc_arr[i]  = 32'd12;
            ret_arr[i] = (i == 0);
        end
        exp_q.push_back({1'b1, 32'd1, 32'd17});
        run_and_check("clear_done", 1'b1, 1, 1'b0);
        clear        = 1'b1;
        result_ready = 1'b1;
        tick();
        clear        = 1'b0;
        result_ready = 1'b0;
        total++;
        if ({busy, result_valid, timeout, cycle_count, instr_count} !== 67'd0) begin
            bad++;
            $display("FAIL clear_done_idle: busy=%b rv=%b to=%b cyc=%0d ins=%0d required all 0",
                     busy, result_valid, timeout, cycle_count, instr_count);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 14; r++) begin
            gen_random();
            void'(model_end(1'b1));
            run_and_check($sformatf("random%0d", r), 1'b1, $urandom_range(0, 4), 1'b1);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_linear();
        test_alternate();
        test_stall();
        test_stall_after_retires();
        test_priority();
        test_async_reset();
        test_clear_start();
        test_clear_done();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
